// File: rtl/cdecv_run_pkg.sv
// Shared constants and types for the CPU run controller.
// State encodings and counter width used by run_controller and its counters.
package cdecv_run_pkg;

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_CYCLE  = 3'd3,
        ST_HALTED = 3'd4
    } run_state_t;

    function automatic logic is_active(run_state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_CYCLE);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Holds at CNT_MAX instead of wrapping.
module sat_counter16
    import cdecv_run_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    // Count register: clear first, then increment unless already at max
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Monitor-driven run/step/cycle controller gating the CPU clock enable.
// Optional breakpoint logic is built when CDECV_BREAKPOINT_EN is defined.
module run_controller
    import cdecv_run_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             cyc_req,
    input  logic             cnt_clr,
    input  logic             end_sq,
    input  logic             pause_cc,
    input  logic             halted,
    input  logic             at_f0,
    input  logic [7:0]       pc,
`ifdef CDECV_BREAKPOINT_EN
    input  logic [7:0]       bp_addr,
    input  logic             bp_valid,
`endif
    output logic             cpu_en,
    output logic [2:0]       run_state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic             bp_hit
);

    run_state_t state;
    run_state_t state_nxt;
    logic       bp_match;

`ifdef CDECV_BREAKPOINT_EN
    logic arm_q;
    logic bp_hit_q;

    assign bp_match = (state == ST_RUN) && arm_q && bp_valid
                   && at_f0 && (pc == bp_addr);

    // Arm only after RUN has executed once, so resuming at the
    // breakpoint address does not immediately stop again
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_q <= 1'b0;
        end else if (state != ST_RUN && state_nxt == ST_RUN) begin
            arm_q <= 1'b0;
        end else if (state == ST_RUN && cpu_en) begin
            arm_q <= 1'b1;
        end
    end

    // Sticky hit flag, cleared when the monitor issues the next run
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bp_hit_q <= 1'b0;
        end else if (bp_match) begin
            bp_hit_q <= 1'b1;
        end else if (state == ST_IDLE && run_req) begin
            bp_hit_q <= 1'b0;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp_inputs;

    assign unused_bp_inputs = ^{pc, at_f0};
    assign bp_match = 1'b0;
    assign bp_hit   = 1'b0;
`endif

    assign cpu_en    = is_active(state) && !halted && !bp_match;
    assign run_state = state;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; halted dominates every active state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (run_req) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end else if (cyc_req) begin
                    state_nxt = ST_CYCLE;
                end
            end
            ST_RUN: begin
                if (halted) begin
                    state_nxt = ST_HALTED;
                end else if (stop_req || bp_match) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halted) begin
                    state_nxt = ST_HALTED;
                end else if (stop_req || (cpu_en && end_sq)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CYCLE: begin
                if (halted) begin
                    state_nxt = ST_HALTED;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    sat_counter16 u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cpu_en && !pause_cc),
        .clr   (cnt_clr),
        .q     (cycle_count)
    );

    sat_counter16 u_instr_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cpu_en && end_sq),
        .clr   (cnt_clr),
        .q     (instr_count)
    );

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: per-cycle model compare
// plus literal expectations for each directed scenario.
module tb_run_controller;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_CYCLE  = 3;
    localparam int M_HALTED = 4;
    localparam int C_MAX    = 65535;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run_req = 1'b0;
    logic        stop_req = 1'b0;
    logic        step_req = 1'b0;
    logic        cyc_req = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        end_sq = 1'b0;
    logic        pause_cc = 1'b0;
    logic        halted = 1'b0;
    logic        at_f0 = 1'b0;
    logic [7:0]  pc = 8'h00;
`ifdef CDECV_BREAKPOINT_EN
    logic [7:0]  bp_addr = 8'h00;
    logic        bp_valid = 1'b0;
`endif
    logic        cpu_en;
    logic [2:0]  run_state;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;
    logic        bp_hit;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    int m_mode = M_IDLE;
    int m_cc = 0;
    int m_ic = 0;
    bit m_bph = 1'b0;
`ifdef CDECV_BREAKPOINT_EN
    int m_runen = 0;
`endif

    run_controller dut (
        .clock       (clock),
        .reset       (reset),
        .run_req     (run_req),
        .stop_req    (stop_req),
        .step_req    (step_req),
        .cyc_req     (cyc_req),
        .cnt_clr     (cnt_clr),
        .end_sq      (end_sq),
        .pause_cc    (pause_cc),
        .halted      (halted),
        .at_f0       (at_f0),
        .pc          (pc),
`ifdef CDECV_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
`endif
        .cpu_en      (cpu_en),
        .run_state   (run_state),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .bp_hit      (bp_hit)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_hit();
`ifdef CDECV_BREAKPOINT_EN
        return (m_mode == M_RUN) && (m_runen > 0) && bp_valid
            && at_f0 && (pc == bp_addr);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_en();
        return (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_CYCLE)
            && !halted && !m_hit();
    endfunction

    // Behavioural model: mode plus plain integer counters
    always @(posedge clock or posedge reset) begin : model
        bit en;
        bit hit;
        int nm;
        if (reset) begin
            m_mode = M_IDLE;
            m_cc = 0;
            m_ic = 0;
            m_bph = 1'b0;
`ifdef CDECV_BREAKPOINT_EN
            m_runen = 0;
`endif
        end else begin
            hit = m_hit();
            en = m_en();
            nm = m_mode;
            if (m_mode == M_IDLE) begin
                if (stop_req) nm = M_IDLE;
                else if (run_req) nm = M_RUN;
                else if (step_req) nm = M_STEP;
                else if (cyc_req) nm = M_CYCLE;
            end else if (m_mode != M_HALTED && halted) begin
                nm = M_HALTED;
            end else if (m_mode == M_RUN) begin
                if (stop_req || hit) nm = M_IDLE;
            end else if (m_mode == M_STEP) begin
                if (stop_req || (en && end_sq)) nm = M_IDLE;
            end else if (m_mode == M_CYCLE) begin
                nm = M_IDLE;
            end
            if (cnt_clr) m_cc = 0;
            else if (en && !pause_cc && m_cc < C_MAX) m_cc = m_cc + 1;
            if (cnt_clr) m_ic = 0;
            else if (en && end_sq && m_ic < C_MAX) m_ic = m_ic + 1;
`ifdef CDECV_BREAKPOINT_EN
            if (m_mode != M_RUN && nm == M_RUN) m_runen = 0;
            else if (m_mode == M_RUN && en) m_runen = m_runen + 1;
`endif
            if (hit) m_bph = 1'b1;
            else if (m_mode == M_IDLE && run_req) m_bph = 1'b0;
            m_mode = nm;
        end
    end

    // Compare every cycle mid-period, while inputs are stable
    always @(negedge clock) begin
        if (!reset) begin
            chk("cmp_state", int'(run_state), m_mode);
            chk("cmp_cpu_en", int'(cpu_en), int'(m_en()));
            chk("cmp_cycle_count", int'(cycle_count), m_cc);
            chk("cmp_instr_count", int'(instr_count), m_ic);
            chk("cmp_bp_hit", int'(bp_hit), int'(m_bph));
            if (cpu_en) en_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        chk("reset_state", int'(run_state), 0);
        chk("reset_cpu_en", int'(cpu_en), 0);
        chk("reset_cycle_count", int'(cycle_count), 0);
        chk("reset_instr_count", int'(instr_count), 0);
        chk("reset_bp_hit", int'(bp_hit), 0);
        tick();

        en_cnt = 0;
        cyc_req = 1'b1;
        tick();
        cyc_req = 1'b0;
        repeat (3) tick();
        chk("cyc_en_cycles", en_cnt, 1);
        chk("cyc_cycle_count", int'(cycle_count), 1);
        chk("cyc_state", int'(run_state), 0);

        clear_counts();
        en_cnt = 0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (3) tick();
        end_sq = 1'b1;
        tick();
        end_sq = 1'b0;
        tick();
        chk("step_en_cycles", en_cnt, 4);
        chk("step_instr_count", int'(instr_count), 1);
        chk("step_cycle_count", int'(cycle_count), 4);
        chk("step_state", int'(run_state), 0);

        clear_counts();
        en_cnt = 0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            pause_cc = (i == 3 || i == 4);
            stop_req = (i == 10);
            tick();
        end
        pause_cc = 1'b0;
        stop_req = 1'b0;
        repeat (2) tick();
        chk("run_en_cycles", en_cnt, 10);
        chk("run_cycle_count", int'(cycle_count), 8);
        chk("run_state", int'(run_state), 0);

        cyc_req = 1'b1;
        tick();
        cyc_req = 1'b0;
        cnt_clr = 1'b1;
        end_sq = 1'b1;
        tick();
        cnt_clr = 1'b0;
        end_sq = 1'b0;
        tick();
        chk("clr_wins_cycle", int'(cycle_count), 0);
        chk("clr_wins_instr", int'(instr_count), 0);

        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("step_abort_state", int'(run_state), 0);
        tick();

        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        cyc_req = 1'b1;
        tick();
        cyc_req = 1'b0;
        repeat (65540) tick();
        chk("sat_cycle_count", int'(cycle_count), 16'hFFFF);
        chk("sat_still_run", int'(run_state), 1);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        tick();
        chk("sat_hold", int'(cycle_count), 16'hFFFF);
        chk("sat_stop_state", int'(run_state), 0);

        clear_counts();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (3) tick();
        halted = 1'b1;
        tick();
        halted = 1'b0;
        en_cnt = 0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        cyc_req = 1'b1;
        tick();
        cyc_req = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (2) tick();
        chk("halt_state", int'(run_state), 4);
        chk("halt_en_cycles", en_cnt, 0);
        chk("halt_cpu_en", int'(cpu_en), 0);
        chk("halt_cycle_count", int'(cycle_count), 3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", int'(run_state), 0);
        chk("async_rst_cycle", int'(cycle_count), 0);
        chk("async_rst_cpu_en", int'(cpu_en), 0);
        #3 reset = 1'b0;
        tick();

        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midstep_rst_state", int'(run_state), 0);
        chk("midstep_rst_cpu_en", int'(cpu_en), 0);
        chk("midstep_rst_cycle", int'(cycle_count), 0);
        #3 reset = 1'b0;
        tick();

`ifdef CDECV_BREAKPOINT_EN
        bp_addr = 8'h05;
        bp_valid = 1'b1;
        at_f0 = 1'b1;
        pc = 8'h00;
        clear_counts();
        en_cnt = 0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        for (int p = 0; p <= 5; p++) begin
            pc = 8'(p);
            tick();
        end
        chk("bp_hit_set", int'(bp_hit), 1);
        chk("bp_state", int'(run_state), 0);
        chk("bp_en_cycles", en_cnt, 5);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("bp_hit_cleared", int'(bp_hit), 0);
        for (int p = 5; p <= 8; p++) begin
            pc = 8'(p);
            tick();
        end
        chk("bp_no_rehit_state", int'(run_state), 1);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        tick();
        chk("bp_resume_en", en_cnt, 10);
        chk("bp_resume_hit", int'(bp_hit), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
